sc_stream_decoder: RTL and testbench

Stochastic-to-binary output stage that sits directly downstream of the stochastic `circuit` block. It consumes the `output_circuit` bit stream. Over one measurement window of 2^WIDTH−1 clock cycles it counts the ones in the stream and reports the binary value. It also compares that value with the expected binary value for the window and accumulates error statistics, which are used to evaluate circuit accuracy across successive windows.

---
 rtl/sc_stream_decoder.sv | 114 +++++++++++
 tb/tb_sc_stream_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary output stage: counts ones in the stream over a 2^WIDTH-1 cycle
// window, reports the count and its error against an expected value, and keeps error statistics.
module sc_stream_decoder #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic [WIDTH-1:0]     expected,
    input  logic                 clr_stats,
    output logic                 busy,
    output logic [WIDTH-1:0]     result,
    output logic                 result_valid,
    output logic [WIDTH-1:0]     abs_err,
    output logic [ACC_WIDTH-1:0] err_sum,
    output logic [WIDTH-1:0]     err_max,
    output logic [15:0]          win_count
);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    // Sample index of the N-th (last) sample in the window, N = 2^WIDTH-1
    localparam logic [WIDTH-1:0] LAST = WIDTH'((2 ** WIDTH) - 2);

    state_t               state;
    logic [WIDTH-1:0]     ones;
    logic [WIDTH-1:0]     cnt;
    logic [WIDTH-1:0]     exp_q;

    logic [WIDTH:0]       diff;
    logic [WIDTH:0]       diff_neg;
    logic [WIDTH-1:0]     err_now;
    logic [ACC_WIDTH:0]   err_ext;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] sum_sat;

    always_comb begin
        diff     = {1'b0, ones} - {1'b0, exp_q};
        diff_neg = -diff;
        err_now  = diff[WIDTH] ? diff_neg[WIDTH-1:0] : diff[WIDTH-1:0];
        err_ext  = '0;
        err_ext[WIDTH-1:0] = err_now;
        sum_ext  = {1'b0, err_sum} + err_ext;
        sum_sat  = sum_ext[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : sum_ext[ACC_WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            ones         <= '0;
            cnt          <= '0;
            exp_q        <= '0;
            busy         <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            abs_err      <= '0;
            err_sum      <= '0;
            err_max      <= '0;
            win_count    <= '0;
        end else begin
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        exp_q <= expected;
                        ones  <= '0;
                        cnt   <= '0;
                        state <= COUNT;
                        busy  <= 1'b1;
                    end
                end
                COUNT: begin
                    ones <= ones + WIDTH'(bit_in);
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= DONE;
                end
                DONE: begin
                    result       <= ones;
                    abs_err      <= err_now;
                    result_valid <= 1'b1;
                    err_sum      <= sum_sat;
                    if (err_now > err_max)
                        err_max <= err_now;
                    if (win_count != 16'hFFFF)
                        win_count <= win_count + 16'd1;
                    // The DONE cycle's bit_in is deliberately not sampled
                    if (start) begin
                        exp_q <= expected;
                        ones  <= '0;
                        cnt   <= '0;
                        state <= COUNT;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            // Clear overrides any accumulation on the same edge
            if (clr_stats) begin
                err_sum   <= '0;
                err_max   <= '0;
                win_count <= '0;
            end
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Directed self-checking bench for sc_stream_decoder at default parameters (N = 255).
module tb_sc_stream_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        bit_in = 1'b0;
    logic [7:0]  expected = '0;
    logic        clr_stats = 1'b0;
    logic        busy;
    logic [7:0]  result;
    logic        result_valid;
    logic [7:0]  abs_err;
    logic [23:0] err_sum;
    logic [7:0]  err_max;
    logic [15:0] win_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int nvalid = 0;

    sc_stream_decoder #(.WIDTH(8), .ACC_WIDTH(24)) dut (
        .clk(clk), .rst(rst), .start(start), .bit_in(bit_in), .expected(expected),
        .clr_stats(clr_stats), .busy(busy), .result(result), .result_valid(result_valid),
        .abs_err(abs_err), .err_sum(err_sum), .err_max(err_max), .win_count(win_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (result_valid) nvalid <= nvalid + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: all ones, 1: all zeros, 2: alternating starting with 1 on E1.
    // clr_k: negedge index at which clr_stats is raised for one edge (-1 = never).
    task automatic do_window(input logic [7:0] e, input int mode, input int clr_k, output int lat);
        int e0;
        @(negedge clk);
        start = 1'b1; expected = e; bit_in = 1'b0; e0 = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            if (result_valid) begin
                lat = cyc - e0;
                break;
            end
            bit_in    = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : ((k % 2) == 0);
            clr_stats = (k == clr_k);
            @(negedge clk);
        end
        clr_stats = 1'b0;
    endtask

    initial begin
        int lat, v1, v2, e0, nv0;

        // Reset state
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_abs_err", abs_err, 0);
        chk("rst_err_sum", err_sum, 0);
        chk("rst_err_max", err_max, 0);
        chk("rst_win_count", win_count, 0);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("idle_no_valid", nvalid, 0);
        chk("idle_busy", busy, 0);

        // All ones, expected 255
        do_window(8'd255, 0, -1, lat);
        chk("ones_latency", lat, 256);
        chk("ones_result", result, 255);
        chk("ones_abs_err", abs_err, 0);
        chk("ones_win_count", win_count, 1);
        chk("ones_err_sum", err_sum, 0);
        @(negedge clk);
        chk("ones_valid_pulse", result_valid, 0);
        chk("ones_busy_after", busy, 0);

        // All zeros, expected 200
        do_window(8'd200, 1, -1, lat);
        chk("zeros_result", result, 0);
        chk("zeros_abs_err", abs_err, 200);
        chk("zeros_err_sum", err_sum, 200);
        chk("zeros_err_max", err_max, 200);
        chk("zeros_win_count", win_count, 2);

        // Alternating, 128 ones, expected 100
        do_window(8'd100, 2, -1, lat);
        chk("alt_result", result, 128);
        chk("alt_abs_err", abs_err, 28);
        chk("alt_err_sum", err_sum, 228);
        chk("alt_err_max", err_max, 200);
        chk("alt_win_count", win_count, 3);

        // Back-to-back windows with start held; expected changes mid-window
        @(negedge clk);
        start = 1'b1; expected = 8'd5; bit_in = 1'b1; e0 = cyc + 1;
        v1 = -1; v2 = -1;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (k == 100) expected = 8'd77;
            if (k == 300) start = 1'b0;
            if (k == 350) start = 1'b1;
            if (k == 351) start = 1'b0;
            if (result_valid) begin
                if (v1 < 0) begin
                    v1 = cyc - e0;
                    chk("b2b_abs_err1", abs_err, 250);
                    chk("b2b_busy_held", busy, 1);
                end else begin
                    v2 = cyc - e0;
                    break;
                end
            end
        end
        chk("b2b_first_latency", v1, 256);
        chk("b2b_spacing", v2 - v1, 256);
        chk("b2b_result2", result, 255);
        chk("b2b_abs_err2", abs_err, 178);
        chk("b2b_err_sum", err_sum, 656);
        chk("b2b_err_max", err_max, 250);
        chk("b2b_win_count", win_count, 5);
        @(negedge clk);
        chk("b2b_idle_busy", busy, 0);

        // Abort with asynchronous reset after 100 samples
        nv0 = nvalid;
        @(negedge clk);
        start = 1'b1; expected = 8'd0; bit_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (100) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_result", result, 0);
        chk("abort_win_count", win_count, 0);
        chk("abort_err_sum", err_sum, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        chk("abort_no_valid", nvalid - nv0, 0);
        do_window(8'd250, 0, -1, lat);
        chk("after_abort_latency", lat, 256);
        chk("after_abort_result", result, 255);
        chk("after_abort_abs_err", abs_err, 5);
        chk("after_abort_err_sum", err_sum, 5);
        chk("after_abort_win_count", win_count, 1);

        // clr_stats coincident with the DONE edge
        do_window(8'd0, 0, 255, lat);
        chk("clr_latency", lat, 256);
        chk("clr_valid", result_valid, 1);
        chk("clr_result", result, 255);
        chk("clr_abs_err", abs_err, 255);
        chk("clr_err_sum", err_sum, 0);
        chk("clr_err_max", err_max, 0);
        chk("clr_win_count", win_count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
